// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the 4-input truth-table checker.
package truth_table_checker_pkg;

    localparam int VEC_W    = 4;
    localparam int NUM_VECS = 16;

    localparam logic [NUM_VECS-1:0] DEFAULT_TRUTH_TABLE = 16'hC4F4;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter that paces the gap between driving a vector and sampling it.
module truth_table_checker_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive ABCD stimulus generator and response checker for a 4-input, 1-output block.
// Optional fail_mask output is enabled by defining TRUTH_TABLE_CHECKER_FAIL_MASK_EN.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter logic [NUM_VECS-1:0] TRUTH_TABLE   = DEFAULT_TRUTH_TABLE,
    parameter int                  SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                vec_a,
    output logic                vec_b,
    output logic                vec_c,
    output logic                vec_d,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [4:0]          err_count,
    output logic                first_fail_valid,
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
    output logic [NUM_VECS-1:0] fail_mask,
`endif
    output logic [VEC_W-1:0]    first_fail_idx
);

    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VECS - 1);
    localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t           state, state_next;
    logic [VEC_W-1:0] idx;
    logic [VEC_W-1:0] vec_q;
    logic             settle_zero;
    logic             in_run;
    logic             start_run;
    logic             mismatch;
    logic [4:0]       err_next;

    assign in_run    = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
    assign start_run = ((state == IDLE) || (state == DONE)) && start;
    assign mismatch  = (dut_out != TRUTH_TABLE[idx]);
    assign err_next  = err_count + 5'(mismatch);

    // Loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES cycles.
    truth_table_checker_settle_timer #(
        .W(4)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == DRIVE),
        .load_val (SETTLE_LOAD),
        .en       (state == SETTLE),
        .zero     (settle_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = DRIVE;
            end
            DRIVE: begin
                if (abort)                   state_next = IDLE;
                else if (SETTLE_CYCLES == 0) state_next = SAMPLE;
                else                         state_next = SETTLE;
            end
            SETTLE: begin
                if (abort)            state_next = IDLE;
                else if (settle_zero) state_next = SAMPLE;
            end
            SAMPLE: begin
                if (abort)                 state_next = IDLE;
                else if (idx == LAST_IDX)  state_next = DONE;
                else                       state_next = DRIVE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Vectors are loaded on entry to DRIVE so the DUT sees them for the whole vector slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx              <= '0;
            vec_q            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
            fail_mask        <= '0;
`endif
        end else if (start_run) begin
            idx              <= '0;
            vec_q            <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
            fail_mask        <= '0;
`endif
        end else if (in_run && abort) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else if (state == SAMPLE) begin
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= idx;
            end
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
            if (mismatch) fail_mask[idx] <= 1'b1;
`endif
            if (idx == LAST_IDX) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_next == 5'd0);
            end else begin
                idx   <= idx + 1'b1;
                vec_q <= idx + 1'b1;
            end
        end
    end

    assign vec_a = vec_q[3];
    assign vec_b = vec_q[2];
    assign vec_c = vec_q[1];
    assign vec_d = vec_q[0];

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: one instance with SETTLE_CYCLES=1, one with 0.
module tb_truth_table_checker;

    localparam logic [15:0] TT_REF = 16'hC4F4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, abort0, dut_out0;
    logic       va0, vb0, vc0, vd0, busy0, done0, pass0, ffv0;
    logic [4:0] err0;
    logic [3:0] ffi0;
    logic       start1, abort1, dut_out1;
    logic       va1, vb1, vc1, vd1, busy1, done1, pass1, ffv1;
    logic [4:0] err1;
    logic [3:0] ffi1;
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
    logic [15:0] mask0, mask1;
`endif

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    logic [4:0] err_at_start;

    // 0: correct table, 1: (A&~B)|(A&B&C)|(C&~D), 2: tied 0, 3: tied 1
    function automatic logic model(input int m, input logic [3:0] v);
        case (m)
            0:       return TT_REF[v];
            1:       return (v[3] & ~v[2]) | (v[3] & v[2] & v[1]) | (v[1] & ~v[0]);
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign dut_out0 = model(mode, {va0, vb0, vc0, vd0});
    assign dut_out1 = model(0, {va1, vb1, vc1, vd1});

    truth_table_checker #(.TRUTH_TABLE(16'hC4F4), .SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .vec_a(va0), .vec_b(vb0), .vec_c(vc0), .vec_d(vd0), .dut_out(dut_out0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_valid(ffv0),
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
        .fail_mask(mask0),
`endif
        .first_fail_idx(ffi0)
    );

    truth_table_checker #(.TRUTH_TABLE(16'hC4F4), .SETTLE_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .vec_a(va1), .vec_b(vb1), .vec_c(vc1), .vec_d(vd1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_valid(ffv1),
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
        .fail_mask(mask1),
`endif
        .first_fail_idx(ffi1)
    );

    // Pulses start on u_dut0 and counts edges after edge 0 until done reads 1.
    task automatic run0(output int cycles);
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        err_at_start = err0;
        cycles = 0;
        while (cycles < 200 && !done0) begin
            @(posedge clk); #1; cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({busy0, done0, pass0, err0, ffv0, ffi0, va0, vb0, vc0, vd0} !== 18'd0) begin
            bad++; $display("FAIL reset_dut0: got %h want 0", {busy0, done0, pass0, err0, ffv0, ffi0, va0, vb0, vc0, vd0}); end
        total++; if ({busy1, done1, pass1, err1, ffv1, ffi1, va1, vb1, vc1, vd1} !== 18'd0) begin
            bad++; $display("FAIL reset_dut1: got %h want 0", {busy1, done1, pass1, err1, ffv1, ffi1, va1, vb1, vc1, vd1}); end
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
        total++; if (mask0 !== 16'h0) begin bad++; $display("FAIL reset_mask: got %h want 0000", mask0); end
`endif
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_correct();
        int c;
        mode = 0;
        run0(c);
        total++; if (c !== 48) begin bad++; $display("FAIL correct_latency: got %0d want 48", c); end
        total++; if (pass0 !== 1'b1) begin bad++; $display("FAIL correct_pass: got %b want 1", pass0); end
        total++; if (err0 !== 5'd0) begin bad++; $display("FAIL correct_err: got %0d want 0", err0); end
        total++; if (ffv0 !== 1'b0) begin bad++; $display("FAIL correct_ffv: got %b want 0", ffv0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL correct_busy: got %b want 0", busy0); end
    endtask

    task automatic test_expr();
        int c;
        mode = 1;
        run0(c);
        total++; if (err0 !== 5'd6) begin bad++; $display("FAIL expr_err: got %0d want 6", err0); end
        total++; if (ffi0 !== 4'd4) begin bad++; $display("FAIL expr_ffi: got %0d want 4", ffi0); end
        total++; if (ffv0 !== 1'b1) begin bad++; $display("FAIL expr_ffv: got %b want 1", ffv0); end
        total++; if (pass0 !== 1'b0 || done0 !== 1'b1) begin
            bad++; $display("FAIL expr_pass_done: got pass=%b done=%b want 0 1", pass0, done0); end
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
        total++; if (mask0 !== 16'h0BB0) begin bad++; $display("FAIL expr_mask: got %h want 0bb0", mask0); end
`endif
    endtask

    task automatic test_tied();
        int c;
        mode = 2;
        run0(c);
        total++; if (err0 !== 5'd8) begin bad++; $display("FAIL tied0_err: got %0d want 8", err0); end
        total++; if (ffi0 !== 4'd2) begin bad++; $display("FAIL tied0_ffi: got %0d want 2", ffi0); end
        mode = 3;
        run0(c);
        total++; if (err0 !== 5'd8) begin bad++; $display("FAIL tied1_err: got %0d want 8", err0); end
        total++; if (ffi0 !== 4'd0 || ffv0 !== 1'b1) begin
            bad++; $display("FAIL tied1_ffi: got %0d/%b want 0/1", ffi0, ffv0); end
    endtask

    task automatic test_settle_zero();
        int k;
        int seq_bad;
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        k = 0; seq_bad = 0;
        while (k < 200 && !done1) begin
            if (k < 32 && {va1, vb1, vc1, vd1} !== 4'(k / 2)) seq_bad++;
            @(posedge clk); #1; k++;
        end
        total++; if (k !== 32) begin bad++; $display("FAIL s0_latency: got %0d want 32", k); end
        total++; if (seq_bad !== 0) begin bad++; $display("FAIL s0_vec_seq: got %0d bad cycles want 0", seq_bad); end
        total++; if (pass1 !== 1'b1) begin bad++; $display("FAIL s0_pass: got %b want 1", pass1); end
    endtask

    task automatic test_abort();
        int c;
        mode = 2;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (10) @(posedge clk);
        #1; abort0 = 1'b1;
        @(posedge clk); #1; abort0 = 1'b0;
        total++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            bad++; $display("FAIL abort_flags: got busy=%b done=%b want 0 0", busy0, done0); end
        total++; if (err0 !== 5'd1 || ffi0 !== 4'd2 || ffv0 !== 1'b1) begin
            bad++; $display("FAIL abort_partial: got err=%0d ffi=%0d ffv=%b want 1 2 1", err0, ffi0, ffv0); end
        @(negedge clk); abort0 = 1'b1;
        @(negedge clk); abort0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (err0 !== 5'd1 || busy0 !== 1'b0) begin
            bad++; $display("FAIL abort_idle: got err=%0d busy=%b want 1 0", err0, busy0); end
        run0(c);
        total++; if (err_at_start !== 5'd0) begin bad++; $display("FAIL restart_clear: got %0d want 0", err_at_start); end
        total++; if (c !== 48 || err0 !== 5'd8 || ffi0 !== 4'd2) begin
            bad++; $display("FAIL restart_result: got c=%0d err=%0d ffi=%0d want 48 8 2", c, err0, ffi0); end
    endtask

    task automatic test_rst_mid();
        mode = 2;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        total++; if (busy0 !== 1'b1 || {va0, vb0, vc0, vd0} !== 4'd2) begin
            bad++; $display("FAIL rst_pre: got busy=%b vec=%0d want 1 2", busy0, {va0, vb0, vc0, vd0}); end
        #3; rst = 1'b1;
        #1;
        total++; if ({busy0, done0, pass0, err0, ffv0, ffi0, va0, vb0, vc0, vd0} !== 18'd0) begin
            bad++; $display("FAIL rst_async: got %h want 0", {busy0, done0, pass0, err0, ffv0, ffi0, va0, vb0, vc0, vd0}); end
        #2; rst = 1'b0;
    endtask

    task automatic test_start_busy();
        int k;
        mode = 0;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        k = 0;
        while (k < 200 && !done0) begin
            if (k == 5) start0 = 1'b1;
            if (k == 6) start0 = 1'b0;
            @(posedge clk); #1; k++;
        end
        start0 = 1'b0;
        total++; if (k !== 48) begin bad++; $display("FAIL busy_start_latency: got %0d want 48", k); end
        total++; if (pass0 !== 1'b1 || err0 !== 5'd0) begin
            bad++; $display("FAIL busy_start_result: got pass=%b err=%0d want 1 0", pass0, err0); end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_expr();
        test_tied();
        test_settle_zero();
        test_abort();
        test_rst_mid();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesizable exhaustive stimulus generator and response checker for any 4-input, 1-output combinational block.
- Steps ABCD through all 16 combinations, samples the device-under-test output after a settle window, and compares it against an expected truth table.
- Reports mismatch count, first failing index and pass/fail.
- Sits beside the 4-input logic exercises as their on-chip verification counterpart: the receiving end of the stimulus stream.

Parameters:
- TRUTH_TABLE, 16'hC4F4, expected output; bit i = expected OUT for ABCD = i, with A as MSB.
- SETTLE_CYCLES, 1, idle cycles between driving a vector and sampling the response; range 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run when in IDLE or DONE.
- abort  input  1  terminates a run in progress.
- vec_a  output  1  stimulus A, equal to idx[3].
- vec_b  output  1  stimulus B, equal to idx[2].
- vec_c  output  1  stimulus C, equal to idx[1].
- vec_d  output  1  stimulus D, equal to idx[0].
- dut_out  input  1  device-under-test response.
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE until the next start or rst.
- pass  output  1  valid when done; 1 iff err_count == 0.
- err_count  output  5  number of mismatches, 0..16.
- first_fail_valid  output  1  at least one mismatch seen.
- first_fail_idx  output  4  index of the lowest mismatching vector.

Behaviour:
- All outputs are registered.
- Reset (async, rst=1): state IDLE; idx=0; vec_a..vec_d=0; busy=0; done=0; pass=0; err_count=0; first_fail_valid=0; first_fail_idx=0; settle counter=0.
- IDLE: start=1 → DRIVE; idx=0; clear err_count, first_fail_valid, first_fail_idx, pass, done; busy=1.
- DRIVE (1 cycle): vec_* = idx. If SETTLE_CYCLES == 0 → SAMPLE; otherwise load the settle counter and go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): count down; at zero → SAMPLE. vec_* held stable.
- SAMPLE (1 cycle): compare dut_out against TRUTH_TABLE[idx].
  - On mismatch: err_count += 1.
  - On mismatch with first_fail_valid == 0: latch first_fail_idx = idx and set first_fail_valid = 1.
  - idx == 15 → DONE: busy=0, done=1, pass = (updated err_count == 0).
  - Otherwise: idx += 1 → DRIVE.
- DONE: start=1 behaves exactly as start in IDLE; outputs otherwise hold.
- Latency:
  - Each vector takes 2 + SETTLE_CYCLES cycles.
  - done first reads 1 after edge number 16*(2+SETTLE_CYCLES), counting the edge that samples start as edge 0.
  - With default SETTLE_CYCLES = 1, that is 48 cycles.
- Boundaries:
  - start while busy: ignored.
  - abort while busy: → IDLE at the next edge; busy=0; done=0; results keep their partial values; abort has priority over start and over the SAMPLE update in the same cycle.
  - abort in IDLE or DONE: no effect.
  - idx never wraps; 15 is terminal.
  - err_count saturates naturally at 16 and cannot overflow its 5 bits.
  - rst mid-run: everything returns to reset values immediately.

Optional Feature:
- Macro: TRUTH_TABLE_CHECKER_FAIL_MASK_EN.
- When defined: adds output fail_mask [15:0]. Bit i is set in SAMPLE when vector i mismatches. The mask clears on start and on rst and holds in DONE.
- When undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE);
  - VEC_W=4 and NUM_VECS=16;
  - the default expected-table constant 16'hC4F4.
- One natural sub-module, settle_timer: loadable down-counter with load, count-enable and zero flag, width 4.

Test Plan:
- Correct DUT model (OUT = TRUTH_TABLE[ABCD]) with SETTLE_CYCLES=1, start pulse → done after 48 cycles, pass=1, err_count=0, first_fail_valid=0.
- DUT implementing (A&~B)|(A&B&C)|(C&~D) against 16'hC4F4 → err_count=6, first_fail_idx=4, pass=0; with the feature enabled, fail_mask=16'h0BB0.
- DUT tied to 0 → err_count=8, first_fail_idx=2; DUT tied to 1 → err_count=8, first_fail_idx=0.
- SETTLE_CYCLES=0 → done after 32 cycles; vec_* sequence monitored as 0,1,…,15, with each value held for exactly 2 cycles.
- abort at cycle 10 of a run, then start again → abort leaves busy=0 and done=0; the new run clears err_count, then completes normally and gives the same results as an uninterrupted run.
- rst asserted asynchronously mid-SETTLE → all outputs are zero before the next clock edge; start pulse while busy is ignored and the run length stays unchanged.
